dac_spi_multi_tx: RTL and testbench

- Parametrised multi-channel SPI transmitter for 12-bit serial DACs; next generation of the single-channel DAC serialiser.
- Frames NUM_CH samples simultaneously: one shared SCK/CS pair, one MOSI line per channel.
- SCK is a registered, divided signal. It is never a gated system clock.
- Sits between the DDS sample path and the DAC connector. Adds a valid/ready handshake, a configurable command header, SCK divider and optional change-only update.

---
 rtl/dac_spi_multi_tx.sv | 126 ++++++++++++
 tb/tb_dac_spi_multi_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_multi_tx.sv
// Multi-channel SPI serialiser for 12-bit DACs: one shared SCK/CS pair, one MOSI per channel.
// Each frame is {CMD_VALUE, sample} sent MSB-first, with a valid/ready handshake and optional change-only update.
module dac_spi_multi_tx #(
  parameter int unsigned         DATA_W         = 12,
  parameter int unsigned         NUM_CH         = 2,
  parameter int unsigned         CMD_BITS       = 4,
  parameter logic [CMD_BITS-1:0] CMD_VALUE      = 4'b0011,
  parameter int unsigned         CLK_DIV        = 2,
  parameter bit                  ONLY_ON_CHANGE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     spi_sck,
  output logic                     spi_cs,
  output logic [NUM_CH-1:0]        spi_mosi
);

  localparam int unsigned FRAME_W = CMD_BITS + DATA_W;
  localparam int unsigned CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t                          state;
  logic [CNT_W-1:0]                cnt;
  logic [BIT_W-1:0]                bit_cnt;
  logic [NUM_CH-1:0][FRAME_W-1:0]  shreg;
  logic [NUM_CH*DATA_W-1:0]        cur_sample;
  logic [NUM_CH*DATA_W-1:0]        last_sent;
  logic                            last_valid;
  logic                            phase_end;
  logic                            unchanged;

  assign phase_end = (cnt == CNT_LAST);
  assign unchanged = ONLY_ON_CHANGE && last_valid && (sample_in == last_sent);

  // MOSI is the MSB of each shift register, so it is a flop output and is cleared with the register
  always_comb begin
    spi_mosi = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) spi_mosi[k] = shreg[k][FRAME_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      cur_sample <= '0;
      last_sent  <= '0;
      last_valid <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      spi_sck    <= 1'b0;
      spi_cs     <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready && !unchanged) begin
            for (int unsigned k = 0; k < NUM_CH; k++)
              shreg[k] <= {CMD_VALUE, sample_in[k*DATA_W +: DATA_W]};
            cur_sample <= sample_in;
            bit_cnt    <= BIT_TOP;
            cnt        <= '0;
            spi_cs     <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (phase_end) begin
            cnt <= '0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
            end else begin
              spi_sck <= 1'b0;
              if (bit_cnt == '0) begin
                state <= HOLD;
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
                for (int unsigned k = 0; k < NUM_CH; k++) shreg[k] <= shreg[k] << 1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (phase_end) begin
            cnt        <= '0;
            spi_cs     <= 1'b1;
            shreg      <= '0;
            frame_done <= 1'b1;
            last_sent  <= cur_sample;
            last_valid <= 1'b1;
            state      <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (phase_end) begin
            cnt      <= '0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_multi_tx.sv
// Bench for dac_spi_multi_tx: default instance plus a CLK_DIV=1, 3-channel, always-send instance.
// Expected frames are queued at accept time and compared when the monitor sees CS rise.
module tb_dac_spi_multi_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] a_sample;
  logic        a_valid, a_ready, a_busy, a_fd, a_sck, a_cs;
  logic [1:0]  a_mosi;
  logic [35:0] b_sample;
  logic        b_valid, b_ready, b_busy, b_fd, b_sck, b_cs;
  logic [2:0]  b_mosi;

  dac_spi_multi_tx dut_a (
    .clk(clk), .rst_n(rst_n), .sample_in(a_sample), .in_valid(a_valid), .in_ready(a_ready),
    .busy(a_busy), .frame_done(a_fd), .spi_sck(a_sck), .spi_cs(a_cs), .spi_mosi(a_mosi)
  );

  dac_spi_multi_tx #(.NUM_CH(3), .CMD_VALUE(4'b0000), .CLK_DIV(1), .ONLY_ON_CHANGE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .sample_in(b_sample), .in_valid(b_valid), .in_ready(b_ready),
    .busy(b_busy), .frame_done(b_fd), .spi_sck(b_sck), .spi_cs(b_cs), .spi_mosi(b_mosi)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] qa[$];
  logic [47:0] qb[$];

  // ---------------- monitor A (CLK_DIV=2 -> CS low 66 cycles) ----------------
  int          a_frames = 0, a_len = 0, a_bits = 0, a_gapcnt = 0, a_gap = 0;
  logic        a_act = 1'b0, a_pcs = 1'b1, a_psck = 1'b0;
  logic [1:0]  a_pmosi = '0;
  logic [15:0] a_cap [2];
  logic [31:0] a_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_act = 1'b0; a_pcs = 1'b1; a_psck = 1'b0; a_pmosi = '0; a_gapcnt = 0;
    end else begin
      if (a_pcs && !a_cs) begin
        a_act = 1'b1; a_len = 0; a_bits = 0; a_gap = a_gapcnt; a_gapcnt = 0;
      end
      if (a_cs && a_busy) a_gapcnt++;
      if (a_act && !a_cs) a_len++;
      if (a_act && a_sck && !a_psck) begin
        for (int k = 0; k < 2; k++) a_cap[k] = {a_cap[k][14:0], a_mosi[k]};
        a_bits++;
      end
      if (a_sck && a_psck) check("a_mosi_stable_sck_high", a_mosi, a_pmosi);
      if (a_fd) check("a_fd_at_cs_rise", {a_pcs, a_cs}, 2'b01);
      if (!a_pcs && a_cs && a_act) begin
        a_act = 1'b0;
        a_frames++;
        check("a_cs_low_len", a_len, 66);
        check("a_sck_rises", a_bits, 16);
        check("a_fd_pulse", a_fd, 1'b1);
        check("a_frame_expected", qa.size() > 0, 1'b1);
        if (qa.size() > 0) begin
          a_exp = qa.pop_front();
          check("a_ch0_frame", a_cap[0], a_exp[15:0]);
          check("a_ch1_frame", a_cap[1], a_exp[31:16]);
        end
      end
      a_pcs = a_cs; a_psck = a_sck; a_pmosi = a_mosi;
    end
  end

  // ---------------- monitor B (CLK_DIV=1 -> CS low 33 cycles) ----------------
  int          b_frames = 0, b_len = 0, b_bits = 0;
  logic        b_act = 1'b0, b_pcs = 1'b1, b_psck = 1'b0;
  logic [2:0]  b_pmosi = '0;
  logic [15:0] b_cap [3];
  logic [47:0] b_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      b_act = 1'b0; b_pcs = 1'b1; b_psck = 1'b0; b_pmosi = '0;
    end else begin
      if (b_pcs && !b_cs) begin
        b_act = 1'b1; b_len = 0; b_bits = 0;
      end
      if (b_act && !b_cs) b_len++;
      if (b_act && b_sck && !b_psck) begin
        for (int k = 0; k < 3; k++) b_cap[k] = {b_cap[k][14:0], b_mosi[k]};
        b_bits++;
      end
      if (b_sck && b_psck) check("b_mosi_stable_sck_high", b_mosi, b_pmosi);
      if (b_fd) check("b_fd_at_cs_rise", {b_pcs, b_cs}, 2'b01);
      if (!b_pcs && b_cs && b_act) begin
        b_act = 1'b0;
        b_frames++;
        check("b_cs_low_len", b_len, 33);
        check("b_sck_rises", b_bits, 16);
        check("b_frame_expected", qb.size() > 0, 1'b1);
        if (qb.size() > 0) begin
          b_exp = qb.pop_front();
          check("b_ch0_frame", b_cap[0], b_exp[15:0]);
          check("b_ch1_frame", b_cap[1], b_exp[31:16]);
          check("b_ch2_frame", b_cap[2], b_exp[47:32]);
        end
      end
      b_pcs = b_cs; b_psck = b_sck; b_pmosi = b_mosi;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready_a();
    int n = 0;
    while (!a_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (!a_ready) check("a_ready_wait", a_ready, 1'b1);
  endtask

  task automatic wait_ready_b();
    int n = 0;
    while (!b_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (!b_ready) check("b_ready_wait", b_ready, 1'b1);
  endtask

  task automatic send_a(input logic [23:0] s, input bit expect_frame);
    wait_ready_a();
    a_sample = s;
    a_valid  = 1'b1;
    if (expect_frame) qa.push_back({4'h3, s[23:12], 4'h3, s[11:0]});
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [35:0] s);
    wait_ready_b();
    b_sample = s;
    b_valid  = 1'b1;
    qb.push_back({4'h0, s[35:24], 4'h0, s[23:12], 4'h0, s[11:0]});
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  task automatic ready_latency_a(output int n);
    n = 0;
    while (!a_ready && n < 300) begin @(posedge clk); #1; n++; end
  endtask

  task automatic ready_latency_b(output int n);
    n = 0;
    while (!b_ready && n < 300) begin @(posedge clk); #1; n++; end
  endtask

  task automatic wait_frames_a(input int target);
    int c = 0;
    while (a_frames < target && c < 3000) begin @(posedge clk); #1; c++; end
    check("a_frames_reached", a_frames >= target, 1'b1);
  endtask

  task automatic wait_frames_b(input int target);
    int c = 0;
    while (b_frames < target && c < 3000) begin @(posedge clk); #1; c++; end
    check("b_frames_reached", b_frames >= target, 1'b1);
  endtask

  logic [23:0] b2b [3];

  initial begin
    int lat;
    int base;
    int rises;
    logic psck;

    a_sample = '0; a_valid = 1'b0;
    b_sample = '0; b_valid = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_cs", a_cs, 1'b1);
    check("rst_a_sck", a_sck, 1'b0);
    check("rst_a_mosi", a_mosi, 2'b00);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_a_fd", a_fd, 1'b0);
    check("rst_a_ready", a_ready, 1'b1);
    check("rst_b_cs", b_cs, 1'b1);
    check("rst_b_mosi", b_mosi, 3'b000);
    check("rst_b_busy", b_busy, 1'b0);
    check("rst_b_ready", b_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // first frame; in_ready low for 68 cycles = back in the 69th cycle after the accept cycle
    send_a(24'hABC123, 1'b1);
    check("a_busy_after_accept", a_busy, 1'b1);
    check("a_cs_after_accept", a_cs, 1'b0);
    check("a_mosi_first_bits", a_mosi, 2'b00);
    ready_latency_a(lat);
    check("a_ready_latency", lat, 68);
    check("a_frames_1", a_frames, 1);

    // identical sample is dropped
    send_a(24'hABC123, 1'b0);
    check("a_supp_ready", a_ready, 1'b1);
    check("a_supp_cs", a_cs, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("a_supp_cs_later", a_cs, 1'b1);
    check("a_supp_busy", a_busy, 1'b0);
    check("a_supp_no_frame", a_frames, 1);

    // changed sample is sent
    send_a(24'hABC124, 1'b1);
    wait_frames_a(2);

    // after reset the cleared last-sent value must not suppress an all-zero sample
    wait_ready_a();
    rst_n = 1'b0;
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_a(24'h000000, 1'b1);
    wait_frames_a(3);

    // back-to-back with in_valid held; samples waiting while busy are not consumed early
    b2b[0] = 24'h111222; b2b[1] = 24'h333444; b2b[2] = 24'h555666;
    wait_ready_a();
    base = a_frames;
    a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_sample = b2b[i];
      wait_ready_a();
      qa.push_back({4'h3, b2b[i][23:12], 4'h3, b2b[i][11:0]});
      @(posedge clk); #1;
      if (i == 2) a_valid = 1'b0;
    end
    wait_frames_a(base + 3);
    check("a_b2b_gap_cycles", a_gap, 2);
    wait_ready_a();
    repeat (5) @(posedge clk);
    #1;
    check("a_b2b_frame_count", a_frames, base + 3);
    check("a_b2b_queue_empty", qa.size(), 0);

    // reset at the 7th SCK rising edge
    base = a_frames;
    send_a(24'hDEF456, 1'b1);
    rises = 0;
    psck  = 1'b0;
    for (int c = 0; c < 200 && rises < 7; c++) begin
      @(posedge clk); #1;
      if (a_sck && !psck) rises++;
      psck = a_sck;
    end
    check("a_mid_rises", rises, 7);
    rst_n = 1'b0;
    #1;
    check("a_mid_cs", a_cs, 1'b1);
    check("a_mid_sck", a_sck, 1'b0);
    check("a_mid_mosi", a_mosi, 2'b00);
    check("a_mid_fd", a_fd, 1'b0);
    check("a_mid_busy", a_busy, 1'b0);
    #20;
    qa.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("a_mid_no_frame", a_frames, base);
    send_a(24'hDEF456, 1'b1);
    wait_frames_a(base + 1);

    // CLK_DIV=1, three channels, header 0, always send
    send_b(36'h5A5FFF001);
    ready_latency_b(lat);
    check("b_ready_latency", lat, 34);
    check("b_frames_1", b_frames, 1);
    send_b(36'h5A5FFF001);
    wait_frames_b(2);
    send_b(36'h0F0A5C3E7);
    wait_frames_b(3);

    repeat (5) @(posedge clk);
    #1;
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
